// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_port_arbiter: shares one RAM port between fetch and load/store.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ram_port_arbiter #(
  parameter int ADDR_WIDTH      = 12,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_req_valid,
  input  logic [ADDR_WIDTH-1:0] inst_req_addr,
  output logic                  inst_req_ready,
  output logic                  inst_rsp_valid,
  output logic [31:0]           inst_rsp_rdata,
  input  logic                  data_req_valid,
  input  logic [ADDR_WIDTH-1:0] data_req_addr,
  input  logic [3:0]            data_req_we,
  input  logic [31:0]           data_req_wdata,
  output logic                  data_req_ready,
  output logic                  data_rsp_valid,
  output logic [31:0]           data_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_INST = 2'd1,
    RSP_DATA = 2'd2
  } rsp_sel_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  logic [3:0] streak_q, streak_d;
  rsp_sel_e   rsp_sel_q, rsp_sel_d;
  logic       streak_at_max;
  logic       grant_inst;
  logic       grant_data;

  // Grants are gated by rst_n so both readies read 0 throughout reset.
  always_comb begin
    streak_at_max = (streak_q == STREAK_MAX);
    grant_inst    = rst_n & inst_req_valid & (~data_req_valid | streak_at_max);
    grant_data    = rst_n & data_req_valid & ~(inst_req_valid & streak_at_max);
  end

  always_comb begin
    streak_d = streak_q;
    if (!inst_req_valid || grant_inst) begin
      streak_d = 4'd0;
    end else if (grant_data && !streak_at_max) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_comb begin
    rsp_sel_d = RSP_NONE;
    if (grant_inst) begin
      rsp_sel_d = RSP_INST;
    end else if (grant_data) begin
      rsp_sel_d = RSP_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q  <= 4'd0;
      rsp_sel_q <= RSP_NONE;
    end else begin
      streak_q  <= streak_d;
      rsp_sel_q <= rsp_sel_d;
    end
  end

  // With no grant the address still follows the data side; only we/din are quiet.
  always_comb begin
    ram_addr = data_req_addr;
    ram_we   = 4'd0;
    ram_din  = 32'd0;
    if (grant_inst) begin
      ram_addr = inst_req_addr;
    end else if (grant_data) begin
      ram_we  = data_req_we;
      ram_din = data_req_wdata;
    end
  end

  assign inst_req_ready = grant_inst;
  assign data_req_ready = grant_data;
  assign inst_rsp_valid = (rsp_sel_q == RSP_INST);
  assign data_rsp_valid = (rsp_sel_q == RSP_DATA);
  assign inst_rsp_rdata = inst_rsp_valid ? ram_dout : 32'd0;
  assign data_rsp_rdata = data_rsp_valid ? ram_dout : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ram_port_arbiter: directed bench with a read-first byte-write RAM. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_ram_port_arbiter;

  localparam int ADDR_WIDTH = 12;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  inst_req_valid;
  logic [ADDR_WIDTH-1:0] inst_req_addr;
  logic                  inst_req_ready;
  logic                  inst_rsp_valid;
  logic [31:0]           inst_rsp_rdata;
  logic                  data_req_valid;
  logic [ADDR_WIDTH-1:0] data_req_addr;
  logic [3:0]            data_req_we;
  logic [31:0]           data_req_wdata;
  logic                  data_req_ready;
  logic                  data_rsp_valid;
  logic [31:0]           data_rsp_rdata;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [3:0]            ram_we;
  logic [31:0]           ram_din;
  logic [31:0]           ram_dout;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  int n_vec = 0;
  int n_err = 0;

  ram_port_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr),
    .inst_req_ready(inst_req_ready), .inst_rsp_valid(inst_rsp_valid),
    .inst_rsp_rdata(inst_rsp_rdata),
    .data_req_valid(data_req_valid), .data_req_addr(data_req_addr),
    .data_req_we(data_req_we), .data_req_wdata(data_req_wdata),
    .data_req_ready(data_req_ready), .data_rsp_valid(data_rsp_valid),
    .data_rsp_rdata(data_rsp_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Read-first synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
  end

  function automatic logic [31:0] init_word(input logic [ADDR_WIDTH-1:0] a);
    return 32'h5A00_0000 | {20'd0, a};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    inst_req_valid = 1'b1; inst_req_addr = 12'h010;
    data_req_valid = 1'b1; data_req_addr = 12'h020;
    data_req_we = 4'hF; data_req_wdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (inst_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_inst_ready got %b exp 0", inst_req_ready); end
    n_vec++; if (data_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_data_ready got %b exp 0", data_req_ready); end
    n_vec++; if (ram_we !== 4'h0) begin n_err++; $display("FAIL reset_ram_we got %h exp 0", ram_we); end
    n_vec++; if ({inst_rsp_valid, data_rsp_valid} !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 00", {inst_rsp_valid, data_rsp_valid}); end
    n_vec++; if ({inst_rsp_rdata, data_rsp_rdata} !== 64'd0) begin n_err++; $display("FAIL reset_rdata got %h/%h exp 0", inst_rsp_rdata, data_rsp_rdata); end
    inst_req_valid = 1'b0; data_req_valid = 1'b0; data_req_we = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    inst_req_valid = 1'b1; inst_req_addr = 12'h010;
    #1;
    n_vec++; if ({inst_req_ready, data_req_ready} !== 2'b10) begin n_err++; $display("FAIL fetch_ready got %b exp 10", {inst_req_ready, data_req_ready}); end
    n_vec++; if (ram_addr !== 12'h010 || ram_we !== 4'h0) begin n_err++; $display("FAIL fetch_ram got addr %h we %h exp 010/0", ram_addr, ram_we); end
    @(negedge clk);
    inst_req_valid = 1'b0;
    #1;
    n_vec++; if (inst_rsp_valid !== 1'b1 || inst_rsp_rdata !== 32'h0000_0013) begin n_err++; $display("FAIL fetch_rsp got %b/%h exp 1/00000013", inst_rsp_valid, inst_rsp_rdata); end
    n_vec++; if (data_rsp_valid !== 1'b0 || data_rsp_rdata !== 32'd0) begin n_err++; $display("FAIL fetch_no_data_rsp got %b/%h exp 0/0", data_rsp_valid, data_rsp_rdata); end
    @(negedge clk);
    n_vec++; if (inst_rsp_valid !== 1'b0) begin n_err++; $display("FAIL fetch_rsp_one_cycle got %b exp 0", inst_rsp_valid); end
  endtask

  task automatic test_store_load();
    data_req_valid = 1'b1; data_req_addr = 12'h020;
    data_req_we = 4'b0100; data_req_wdata = 32'hAABB_CCDD;
    #1;
    n_vec++; if (data_req_ready !== 1'b1) begin n_err++; $display("FAIL store_ready got %b exp 1", data_req_ready); end
    n_vec++; if (ram_we !== 4'b0100 || ram_din !== 32'hAABB_CCDD) begin n_err++; $display("FAIL store_ram got we %b din %h exp 0100/aabbccdd", ram_we, ram_din); end
    @(negedge clk);
    data_req_we = 4'h0; data_req_wdata = 32'd0;
    #1;
    n_vec++; if (data_rsp_valid !== 1'b1 || data_rsp_rdata !== 32'h1122_3344) begin n_err++; $display("FAIL store_rsp got %b/%h exp 1/11223344", data_rsp_valid, data_rsp_rdata); end
    n_vec++; if (inst_rsp_valid !== 1'b0) begin n_err++; $display("FAIL store_no_inst_rsp got %b exp 0", inst_rsp_valid); end
    @(negedge clk);
    data_req_valid = 1'b0;
    #1;
    n_vec++; if (data_rsp_valid !== 1'b1 || data_rsp_rdata !== 32'h11BB_3344) begin n_err++; $display("FAIL load_after_store got %b/%h exp 1/11bb3344", data_rsp_valid, data_rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic exp_i [0:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [ADDR_WIDTH-1:0] ia = 12'h100;
    logic [ADDR_WIDTH-1:0] da = 12'h200;
    logic                  prev_i = 1'b0;
    logic [31:0]           prev_word = 32'd0;
    inst_req_valid = 1'b1; data_req_valid = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      inst_req_addr = ia; data_req_addr = da;
      if (k == 10) begin inst_req_valid = 1'b0; data_req_valid = 1'b0; end
      #1;
      if (k > 0) begin
        n_vec++;
        if ({inst_rsp_valid, data_rsp_valid} !== {prev_i, ~prev_i} ||
            (prev_i ? inst_rsp_rdata : data_rsp_rdata) !== prev_word ||
            (prev_i ? data_rsp_rdata : inst_rsp_rdata) !== 32'd0) begin
          n_err++;
          $display("FAIL starve_rsp[%0d] got v=%b i=%h d=%h exp v=%b word %h", k,
                   {inst_rsp_valid, data_rsp_valid}, inst_rsp_rdata, data_rsp_rdata, {prev_i, ~prev_i}, prev_word);
        end
      end
      if (k < 10) begin
        n_vec++;
        if ({inst_req_ready, data_req_ready} !== {exp_i[k], ~exp_i[k]} || ram_addr !== (exp_i[k] ? ia : da)) begin
          n_err++;
          $display("FAIL starve_grant[%0d] got rdy=%b addr %h exp rdy=%b", k,
                   {inst_req_ready, data_req_ready}, ram_addr, {exp_i[k], ~exp_i[k]});
        end
        prev_i    = exp_i[k];
        prev_word = init_word(exp_i[k] ? ia : da);
        if (exp_i[k]) ia = ia + 12'd1; else da = da + 12'd1;
        @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_interleave();
    logic                  is_i [0:3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [ADDR_WIDTH-1:0] adr  [0:3] = '{12'h030, 12'h040, 12'h050, 12'h060};
    for (int k = 0; k <= 4; k++) begin
      inst_req_valid = (k < 4) && is_i[k % 4];
      data_req_valid = (k < 4) && !is_i[k % 4];
      inst_req_addr  = adr[k % 4];
      data_req_addr  = adr[k % 4];
      #1;
      if (k > 0) begin
        n_vec++;
        if ({inst_rsp_valid, data_rsp_valid} !== {is_i[k-1], ~is_i[k-1]} ||
            (is_i[k-1] ? inst_rsp_rdata : data_rsp_rdata) !== init_word(adr[k-1])) begin
          n_err++;
          $display("FAIL interleave_rsp[%0d] got v=%b i=%h d=%h exp v=%b word %h", k,
                   {inst_rsp_valid, data_rsp_valid}, inst_rsp_rdata, data_rsp_rdata,
                   {is_i[k-1], ~is_i[k-1]}, init_word(adr[k-1]));
        end
      end
      if (k < 4) begin
        n_vec++;
        if ({inst_req_ready, data_req_ready} !== {is_i[k], ~is_i[k]}) begin
          n_err++;
          $display("FAIL interleave_grant[%0d] got %b exp %b", k, {inst_req_ready, data_req_ready}, {is_i[k], ~is_i[k]});
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    inst_req_valid = 1'b1; inst_req_addr = 12'h080;
    data_req_valid = 1'b1; data_req_addr = 12'h070; data_req_we = 4'h0;
    // Four data wins leave the streak saturated; inst would win next unless reset clears it.
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++; if ({inst_req_ready, data_req_ready} !== 2'b01) begin n_err++; $display("FAIL mid_pre_grant[%0d] got %b exp 01", k, {inst_req_ready, data_req_ready}); end
      if (k < 3) @(negedge clk);
    end
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (data_rsp_valid !== 1'b0 || data_rsp_rdata !== 32'd0) begin n_err++; $display("FAIL mid_rsp_dropped got %b/%h exp 0/0", data_rsp_valid, data_rsp_rdata); end
    n_vec++; if ({inst_req_ready, data_req_ready} !== 2'b00) begin n_err++; $display("FAIL mid_ready_in_reset got %b exp 00", {inst_req_ready, data_req_ready}); end
    @(negedge clk);
    n_vec++; if (data_rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_still_low got %b exp 0", data_rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if ({inst_req_ready, data_req_ready} !== 2'b01) begin n_err++; $display("FAIL mid_streak_cleared got %b exp 01", {inst_req_ready, data_req_ready}); end
    @(negedge clk);
    inst_req_valid = 1'b0; data_req_valid = 1'b0;
    #1;
    n_vec++; if (data_rsp_valid !== 1'b1 || data_rsp_rdata !== 32'h5A00_0070 || inst_rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_after_release got %b/%h inst %b exp 1/5a000070 inst 0", data_rsp_valid, data_rsp_rdata, inst_rsp_valid); end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = init_word(ADDR_WIDTH'(i));
    mem[12'h010] = 32'h0000_0013;
    mem[12'h020] = 32'h1122_3344;
    ram_dout = 32'd0;
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_store_load();
    test_starvation();
    test_interleave();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire
